// File: rtl/inv_shift_rows_buf.sv
// Inverse ShiftRows stage for the AES decryption round loop, buffered by a small output FIFO.
// Optional INV_SHIFT_ROWS_FWD_EN adds a mode input selecting the forward ShiftRows permutation.
module inv_shift_rows_buf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef INV_SHIFT_ROWS_FWD_EN
    input  logic         mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [2:0]   count,
    output logic         done
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] perm_data;
    logic              fwd;
    logic              push;
    logic              pop;

    // Byte k sits in column k/4, row (k+1)%4; row r rotates by r columns.
    function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] d,
                                                     input logic              forward);
        logic [DATA_W-1:0] res;
        int unsigned       row;
        int unsigned       col;
        int unsigned       src_col;
        int unsigned       src;
        res = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            row     = (k + 1) % 4;
            col     = k / 4;
            src_col = forward ? (col + row) % 4 : (col + 4 - row) % 4;
            src     = src_col * 4 + (k % 4);
            res[8*k +: 8] = d[8*src +: 8];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef INV_SHIFT_ROWS_FWD_EN
    assign fwd = mode;
`else
    assign fwd = 1'b0;
`endif

    assign perm_data = shift_rows(in_data, fwd);
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage; cleared only by reset since flush empties via pointers/count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= perm_data;
        end
    end

    // Pointers, occupancy and accept pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            done <= push;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/inv_shift_rows_buf.md
Name: inv_shift_rows_buf

Overview:
- Inverse ShiftRows stage for the AES decryption datapath. It undoes the encryption-side row rotation on a 128-bit state.
- Input side is a valid/ready handshake; results go into a small output FIFO so a stalled InvSubBytes stage does not stall the round controller.
- Sits between InvAddRoundKey/InvMixColumns output and InvSubBytes input in the decryption round loop.

Parameters:
DEPTH, 2, output FIFO entries (legal 1..4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (state cleared while reset==0)
flush  input  1  synchronous clear of FIFO contents, same cycle priority over push/pop
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  128  AES state to un-shift
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream accepts out_data
out_data  output  128  un-shifted state (head of FIFO)
count  output  3  FIFO occupancy 0..DEPTH
done  output  1  one-cycle pulse for each accepted input, registered with the write

Behaviour:
- Byte k = data[8k+7:8k], k=0..15. Bytes 3,7,11,15 are row 0 and pass unchanged.
- Inverse permutation (out byte = in byte):
  - Row 1: out0=in12, out4=in0, out8=in4, out12=in8.
  - Row 2: out1=in9, out5=in13, out9=in1, out13=in5.
  - Row 3: out2=in6, out6=in10, out10=in14, out14=in2.
- The permutation is combinational on in_data. The result is written into the FIFO tail on push.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count < DEPTH). It is registered-state derived, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = FIFO[rd_ptr]; out_data is 0 when empty.
- Latency: data accepted at edge N is visible on out_data after edge N, i.e. out_valid is high in cycle N+1.
- Pointers wrap modulo DEPTH. count changes as follows:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop. This is legal whenever count is between 1 and DEPTH-1; at count==DEPTH push is blocked.
- Empty: pop is impossible because out_valid is 0. A push into an empty FIFO is not bypassed to the output in the same cycle.
- FIFO order is strict: first in, first out.
- done pulses exactly in the cycle after each push. It is 0 otherwise, including during flush.
- flush=1: rd_ptr, wr_ptr and count go to 0 and done goes to 0. Any push or pop in that cycle is discarded.
- Reset (async, reset==0) values: count=0, pointers=0, out_valid=0, out_data=0, done=0, in_ready=1 once reset is released. FIFO storage is cleared to 0.
- Reset asserted mid-stream drops all buffered states immediately, without waiting for a clock edge.
- Holding in_valid with in_ready low: in_data must be held stable by the source. The block neither samples nor drops it.

Optional Feature:
Macro INV_SHIFT_ROWS_FWD_EN.
- Defined: adds input port mode (1 bit, sampled with in_data on push).
  - mode=1 applies the forward ShiftRows permutation:
    - Row 1: out0=in4, out4=in8, out8=in12, out12=in0.
    - Row 2: out1=in9, out5=in13, out9=in1, out13=in5.
    - Row 3: out2=in14, out6=in2, out10=in6, out14=in10.
  - mode=0 applies the inverse permutation. This lets one instance serve both encrypt and decrypt paths.
- Undefined: no mode port; the inverse permutation is always applied.

Test Plan:
- Reset, then push in_data=128'h0f0e0d0c_0b0a0908_07060504_03020100 -> next cycle out_valid=1, out_data=128'h0f020508_0b0e0104_070a0d00_0306090c, done pulses once, count=1.
- Push 128'h0f0a0500_0b06010c_07020d08_030e0904 (the forward result of the identity vector) -> out_data=128'h0f0e0d0c_0b0a0908_07060504_03020100.
- out_ready=0, push DEPTH=2 distinct states -> count=2, in_ready=0, and a third in_valid is not accepted. Then out_ready=1 -> both states pop in push order and count returns to 0.
- count=1 with push and pop in the same cycle -> count stays 1 and out_data advances to the new state next cycle.
- FIFO holding 2 entries, pulse flush -> count=0, out_valid=0, out_data=0. Repeat with reset pulsed low between edges -> immediate clear.
- With INV_SHIFT_ROWS_FWD_EN, mode=1 push of 128'h0f0e0d0c_0b0a0908_07060504_03020100 -> 128'h0f0a0500_0b06010c_07020d08_030e0904. With mode=0 the output matches the inverse vector above.
